ili9341_spi_sink: RTL



---
 rtl/ili9341_pkg.sv | 19 +
 rtl/spi_byte_rx.sv | 72 +++++++
 rtl/ili9341_spi_sink.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ili9341_pkg.sv
// Shared ILI9341 link definitions used by the display-side sink and the controller.
package ili9341_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned RGB565_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CASET_P = 3'd1,
    ST_PASET_P = 3'd2,
    ST_RAMWR   = 3'd3,
    ST_OTHER_P = 3'd4
  } sink_state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte assembler: pin registers, SCK edge detect, shift register, bit counter.
module spi_byte_rx
  import ili9341_pkg::*;
(
  input  logic              clk_out,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  input  logic              spi_dc,
  output logic              byte_valid_c,
  output logic [BYTE_W-1:0] byte_data_c,
  output logic              byte_dc_c,
  output logic              dc_err_c,
  output logic              cs_c
);

  localparam int unsigned CNT_W = 3;

  logic              sck_q, sck_prev_q, mosi_q, cs_q, dc_q;
  logic              dc_last_q, dc_last_d;
  logic [6:0]        shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              rise_c;

  // Rising SCK edge while selected; deselected edges are ignored.
  assign rise_c       = sck_q & ~sck_prev_q & ~cs_q;
  assign byte_valid_c = rise_c & (bit_cnt_q == CNT_W'(7));
  assign byte_data_c  = {shift_q, mosi_q};
  assign byte_dc_c    = dc_q;
  assign dc_err_c     = rise_c & (bit_cnt_q != CNT_W'(0)) & (dc_q != dc_last_q);
  assign cs_c         = cs_q;

  // Shift/count next state; CS high discards any partial byte.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    dc_last_d = dc_last_q;
    if (cs_q) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (rise_c) begin
      shift_d   = {shift_q[5:0], mosi_q};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      dc_last_d = dc_q;
    end
  end

  // Pin sampling and byte assembly registers.
  always_ff @(posedge clk_out) begin
    if (!rst) begin
      sck_q      <= 1'b0;
      sck_prev_q <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
      dc_q       <= 1'b0;
      dc_last_q  <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
    end else begin
      sck_q      <= spi_sck;
      sck_prev_q <= sck_q;
      mosi_q     <= spi_mosi;
      cs_q       <= spi_cs;
      dc_q       <= spi_dc;
      dc_last_q  <= dc_last_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/ili9341_spi_sink.sv
// ILI9341 receive-side decoder: classifies bytes, tracks CASET/PASET window, emits tagged RGB565 pixels.
module ili9341_spi_sink
  import ili9341_pkg::*;
#(
  parameter int unsigned WIDTH   = 240,
  parameter int unsigned HEIGHT  = 240,
  parameter int unsigned COORD_W = 9
) (
  input  logic                clk_out,
  input  logic                rst,
  input  logic                spi_sck,
  input  logic                spi_mosi,
  input  logic                spi_cs,
  input  logic                spi_dc,
  output logic                cmd_valid,
  output logic [BYTE_W-1:0]   cmd_byte,
  output logic                param_valid,
  output logic [BYTE_W-1:0]   param_byte,
  output logic                pixel_valid,
  output logic [RGB565_W-1:0] pixel_data,
  output logic [COORD_W-1:0]  pixel_x,
  output logic [COORD_W-1:0]  pixel_y,
  output logic                frame_done,
  output logic                protocol_err
);

  localparam int unsigned PBUF_W = 3 * BYTE_W;

  logic              byte_valid_c, byte_dc_c, dc_err_c, cs_c;
  logic [BYTE_W-1:0] byte_data_c;

  sink_state_e         state_q, state_d;
  logic [1:0]          param_cnt_q, param_cnt_d;
  logic                param_done_q, param_done_d;
  logic [PBUF_W-1:0]   param_buf_q, param_buf_d;
  logic [COORD_W-1:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic                pix_half_q, pix_half_d;
  logic [BYTE_W-1:0]   pix_hi_q, pix_hi_d;

  logic                cmd_valid_q, cmd_valid_d;
  logic [BYTE_W-1:0]   cmd_byte_q, cmd_byte_d;
  logic                param_valid_q, param_valid_d;
  logic [BYTE_W-1:0]   param_byte_q, param_byte_d;
  logic                pixel_valid_q, pixel_valid_d;
  logic [RGB565_W-1:0] pixel_data_q, pixel_data_d;
  logic [COORD_W-1:0]  pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic                frame_done_q, frame_done_d;
  logic                protocol_err_q, protocol_err_d;

  spi_byte_rx u_rx (
    .clk_out      (clk_out),
    .rst          (rst),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .spi_cs       (spi_cs),
    .spi_dc       (spi_dc),
    .byte_valid_c (byte_valid_c),
    .byte_data_c  (byte_data_c),
    .byte_dc_c    (byte_dc_c),
    .dc_err_c     (dc_err_c),
    .cs_c         (cs_c)
  );

  // Next-state: command decode, window parameter capture, pixel pairing and pointer walk.
  always_comb begin
    state_d        = state_q;
    param_cnt_d    = param_cnt_q;
    param_done_d   = param_done_q;
    param_buf_d    = param_buf_q;
    xs_d           = xs_q;
    xe_d           = xe_q;
    ys_d           = ys_q;
    ye_d           = ye_q;
    x_d            = x_q;
    y_d            = y_q;
    pix_half_d     = pix_half_q;
    pix_hi_d       = pix_hi_q;
    cmd_valid_d    = 1'b0;
    cmd_byte_d     = cmd_byte_q;
    param_valid_d  = 1'b0;
    param_byte_d   = param_byte_q;
    pixel_valid_d  = 1'b0;
    pixel_data_d   = pixel_data_q;
    pixel_x_d      = pixel_x_q;
    pixel_y_d      = pixel_y_q;
    frame_done_d   = 1'b0;
    protocol_err_d = dc_err_c;

    // A deselect drops a half-received pixel but keeps the FSM state.
    if (cs_c) begin
      pix_half_d = 1'b0;
    end

    if (byte_valid_c) begin
      if (!byte_dc_c) begin
        cmd_valid_d  = 1'b1;
        cmd_byte_d   = byte_data_c;
        pix_half_d   = 1'b0;
        param_cnt_d  = '0;
        param_done_d = 1'b0;
        case (byte_data_c)
          CMD_CASET: state_d = ST_CASET_P;
          CMD_PASET: state_d = ST_PASET_P;
          CMD_RAMWR: begin
            state_d = ST_RAMWR;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          default:   state_d = ST_OTHER_P;
        endcase
      end else begin
        case (state_q)
          ST_RAMWR: begin
            if (!pix_half_q) begin
              pix_hi_d   = byte_data_c;
              pix_half_d = 1'b1;
            end else begin
              pix_half_d    = 1'b0;
              pixel_valid_d = 1'b1;
              pixel_data_d  = {pix_hi_q, byte_data_c};
              pixel_x_d     = x_q;
              pixel_y_d     = y_q;
              if (x_q == xe_q) begin
                x_d = xs_q;
                if (y_q == ye_q) begin
                  y_d          = ys_q;
                  frame_done_d = 1'b1;
                end else begin
                  y_d = y_q + COORD_W'(1);
                end
              end else begin
                x_d = x_q + COORD_W'(1);
              end
            end
          end
          ST_CASET_P, ST_PASET_P: begin
            param_valid_d = 1'b1;
            param_byte_d  = byte_data_c;
            if (!param_done_q) begin
              param_buf_d = {param_buf_q[PBUF_W-BYTE_W-1:0], byte_data_c};
              if (param_cnt_q == 2'd3) begin
                param_done_d = 1'b1;
                if (state_q == ST_CASET_P) begin
                  xs_d = COORD_W'(param_buf_q[PBUF_W-1:BYTE_W]);
                  xe_d = COORD_W'({param_buf_q[BYTE_W-1:0], byte_data_c});
                end else begin
                  ys_d = COORD_W'(param_buf_q[PBUF_W-1:BYTE_W]);
                  ye_d = COORD_W'({param_buf_q[BYTE_W-1:0], byte_data_c});
                end
              end else begin
                param_cnt_d = param_cnt_q + 2'd1;
              end
            end
          end
          default: begin
            param_valid_d = 1'b1;
            param_byte_d  = byte_data_c;
          end
        endcase
      end
    end
  end

  // State, window, pointer and output registers.
  always_ff @(posedge clk_out) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      param_cnt_q    <= '0;
      param_done_q   <= 1'b0;
      param_buf_q    <= '0;
      xs_q           <= '0;
      xe_q           <= COORD_W'(WIDTH - 1);
      ys_q           <= '0;
      ye_q           <= COORD_W'(HEIGHT - 1);
      x_q            <= '0;
      y_q            <= '0;
      pix_half_q     <= 1'b0;
      pix_hi_q       <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_byte_q     <= '0;
      param_valid_q  <= 1'b0;
      param_byte_q   <= '0;
      pixel_valid_q  <= 1'b0;
      pixel_data_q   <= '0;
      pixel_x_q      <= '0;
      pixel_y_q      <= '0;
      frame_done_q   <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      param_cnt_q    <= param_cnt_d;
      param_done_q   <= param_done_d;
      param_buf_q    <= param_buf_d;
      xs_q           <= xs_d;
      xe_q           <= xe_d;
      ys_q           <= ys_d;
      ye_q           <= ye_d;
      x_q            <= x_d;
      y_q            <= y_d;
      pix_half_q     <= pix_half_d;
      pix_hi_q       <= pix_hi_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_byte_q     <= cmd_byte_d;
      param_valid_q  <= param_valid_d;
      param_byte_q   <= param_byte_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_data_q   <= pixel_data_d;
      pixel_x_q      <= pixel_x_d;
      pixel_y_q      <= pixel_y_d;
      frame_done_q   <= frame_done_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_byte     = cmd_byte_q;
  assign param_valid  = param_valid_q;
  assign param_byte   = param_byte_q;
  assign pixel_valid  = pixel_valid_q;
  assign pixel_data   = pixel_data_q;
  assign pixel_x      = pixel_x_q;
  assign pixel_y      = pixel_y_q;
  assign frame_done   = frame_done_q;
  assign protocol_err = protocol_err_q;

endmodule
